// File: rtl/booth_pp_gen_18_if.sv
// Operand/partial-product bus of the radix-4 Booth partial-product generator.
interface booth_pp_gen_18_if #(
  parameter int unsigned MCAND_W = 32,
  parameter int unsigned MPLR_W  = 32,
  parameter int unsigned WORDLEN = 64
);
  logic               in_valid;
  logic               in_ready;
  logic               signed_mode;
  logic [MCAND_W-1:0] mcand;
  logic [MPLR_W-1:0]  mplr;
  logic               out_valid;
  logic               out_ready;
  logic [WORDLEN-1:0] pp_1,  pp_2,  pp_3,  pp_4,  pp_5,  pp_6;
  logic [WORDLEN-1:0] pp_7,  pp_8,  pp_9,  pp_10, pp_11, pp_12;
  logic [WORDLEN-1:0] pp_13, pp_14, pp_15, pp_16, pp_17, pp_18;

  modport master (
    output in_valid, signed_mode, mcand, mplr, out_ready,
    input  in_ready, out_valid,
    input  pp_1,  pp_2,  pp_3,  pp_4,  pp_5,  pp_6,
    input  pp_7,  pp_8,  pp_9,  pp_10, pp_11, pp_12,
    input  pp_13, pp_14, pp_15, pp_16, pp_17, pp_18
  );

  modport slave (
    input  in_valid, signed_mode, mcand, mplr, out_ready,
    output in_ready, out_valid,
    output pp_1,  pp_2,  pp_3,  pp_4,  pp_5,  pp_6,
    output pp_7,  pp_8,  pp_9,  pp_10, pp_11, pp_12,
    output pp_13, pp_14, pp_15, pp_16, pp_17, pp_18
  );
endinterface

// File: rtl/booth_pp_gen_18.sv
// Two-stage radix-4 Booth partial-product generator: stage 1 recodes the
// multiplier into 18 digits, stage 2 forms the shifted partial products.
module booth_pp_gen_18 #(
  parameter int unsigned MCAND_W = 32,
  parameter int unsigned MPLR_W  = 32,
  parameter int unsigned WORDLEN = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  booth_pp_gen_18_if.slave      bus
);

  localparam int unsigned NDIG   = 18;
  localparam int unsigned YEXT_W = 36;

  logic [WORDLEN-1:0] x_ext_c;
  logic [YEXT_W-1:0]  y_ext_c;
  logic [NDIG-1:0]    neg_c, one_c, two_c;

  logic               s1_valid, s2_valid;
  logic [WORDLEN-1:0] s1_x;
  logic [NDIG-1:0]    s1_neg, s1_one, s1_two;

  logic [WORDLEN-1:0] pp_c [NDIG];
  logic [WORDLEN-1:0] pp_q [NDIG];

  logic s2_adv_c, s1_adv_c, in_fire_c;

  // Operand extension: sign bit only replicated in signed mode
  assign x_ext_c = {{(WORDLEN-MCAND_W){bus.signed_mode & bus.mcand[MCAND_W-1]}}, bus.mcand};
  assign y_ext_c = {{(YEXT_W-MPLR_W){bus.signed_mode & bus.mplr[MPLR_W-1]}}, bus.mplr};

  // Booth recoding of overlapping triples {Y[2i+1], Y[2i], Y[2i-1]}, Y[-1]=0
  always_comb begin
    logic [YEXT_W:0] y_pad;
    logic [2:0]      trip;
    neg_c = '0;
    one_c = '0;
    two_c = '0;
    trip  = '0;
    y_pad = {y_ext_c, 1'b0};
    for (int i = 0; i < NDIG; i++) begin
      trip     = y_pad[2*i +: 3];
      neg_c[i] = trip[2] & ~(trip[1] & trip[0]);
      one_c[i] = trip[1] ^ trip[0];
      two_c[i] = (trip == 3'b011) || (trip == 3'b100);
    end
  end

  // Partial products: select X / 2X / 0, negate at full width, align by 2i
  always_comb begin
    logic [WORDLEN-1:0] mag;
    mag = '0;
    for (int i = 0; i < NDIG; i++) begin
      pp_c[i] = '0;
    end
    for (int i = 0; i < NDIG; i++) begin
      if (s1_one[i]) begin
        mag = s1_x;
      end else if (s1_two[i]) begin
        mag = s1_x << 1;
      end else begin
        mag = '0;
      end
      if (s1_neg[i]) begin
        mag = -mag;
      end
      pp_c[i] = mag << (2*i);
    end
  end

  // Handshake: stage 2 frees when empty or consumed; in_ready follows out_ready
  assign s2_adv_c     = !s2_valid || bus.out_ready;
  assign s1_adv_c     = s1_valid && s2_adv_c;
  assign bus.in_ready = !s1_valid || s2_adv_c;
  assign in_fire_c    = bus.in_valid && bus.in_ready;

  // Pipeline valid bits; flush overrides any same-cycle movement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s2_adv_c) begin
        s2_valid <= s1_valid;
      end
      if (in_fire_c) begin
        s1_valid <= 1'b1;
      end else if (s1_adv_c) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 1 data: extended multiplicand and digit encodings
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_x   <= '0;
      s1_neg <= '0;
      s1_one <= '0;
      s1_two <= '0;
    end else if (in_fire_c && !flush) begin
      s1_x   <= x_ext_c;
      s1_neg <= neg_c;
      s1_one <= one_c;
      s1_two <= two_c;
    end
  end

  // Stage 2 data: partial products held stable while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NDIG; i++) begin
        pp_q[i] <= '0;
      end
    end else if (s1_adv_c && !flush) begin
      for (int i = 0; i < NDIG; i++) begin
        pp_q[i] <= pp_c[i];
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.pp_1  = pp_q[0];
  assign bus.pp_2  = pp_q[1];
  assign bus.pp_3  = pp_q[2];
  assign bus.pp_4  = pp_q[3];
  assign bus.pp_5  = pp_q[4];
  assign bus.pp_6  = pp_q[5];
  assign bus.pp_7  = pp_q[6];
  assign bus.pp_8  = pp_q[7];
  assign bus.pp_9  = pp_q[8];
  assign bus.pp_10 = pp_q[9];
  assign bus.pp_11 = pp_q[10];
  assign bus.pp_12 = pp_q[11];
  assign bus.pp_13 = pp_q[12];
  assign bus.pp_14 = pp_q[13];
  assign bus.pp_15 = pp_q[14];
  assign bus.pp_16 = pp_q[15];
  assign bus.pp_17 = pp_q[16];
  assign bus.pp_18 = pp_q[17];

endmodule

// File: tb/tb_booth_pp_gen_18.sv
// Bench for booth_pp_gen_18: directed product table, per-digit checks,
// backpressure, flush, reset and a randomized scoreboard run.
module tb_booth_pp_gen_18;

  localparam int unsigned MCAND_W = 32;
  localparam int unsigned MPLR_W  = 32;
  localparam int unsigned WORDLEN = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  booth_pp_gen_18_if #(.MCAND_W(MCAND_W), .MPLR_W(MPLR_W), .WORDLEN(WORDLEN)) bus ();

  booth_pp_gen_18 #(.MCAND_W(MCAND_W), .MPLR_W(MPLR_W), .WORDLEN(WORDLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [63:0] pps [18];
  assign pps[0]  = bus.pp_1;
  assign pps[1]  = bus.pp_2;
  assign pps[2]  = bus.pp_3;
  assign pps[3]  = bus.pp_4;
  assign pps[4]  = bus.pp_5;
  assign pps[5]  = bus.pp_6;
  assign pps[6]  = bus.pp_7;
  assign pps[7]  = bus.pp_8;
  assign pps[8]  = bus.pp_9;
  assign pps[9]  = bus.pp_10;
  assign pps[10] = bus.pp_11;
  assign pps[11] = bus.pp_12;
  assign pps[12] = bus.pp_13;
  assign pps[13] = bus.pp_14;
  assign pps[14] = bus.pp_15;
  assign pps[15] = bus.pp_16;
  assign pps[16] = bus.pp_17;
  assign pps[17] = bus.pp_18;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        sm;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] exp_sum;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%h required 0x%h", name, act, exp_v);
    end
  endtask

  function automatic logic [63:0] pp_sum();
    logic [63:0] s;
    s = '0;
    for (int k = 0; k < 18; k++) s = s + pps[k];
    return s;
  endfunction

  function automatic logic [63:0] pp_or(input int from);
    logic [63:0] s;
    s = '0;
    for (int k = from; k < 18; k++) s = s | pps[k];
    return s;
  endfunction

  function automatic logic [63:0] ref_prod(input logic sm, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xe, ye;
    xe = sm ? {{32{x[31]}}, x} : {32'h0, x};
    ye = sm ? {{32{y[31]}}, y} : {32'h0, y};
    return xe * ye;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return 32'($urandom());
    endcase
  endfunction

  // One operation on an idle pipeline; lat counts edges from accept to out_valid
  task automatic run_one(input logic sm, input logic [31:0] x, input logic [31:0] y,
                         output logic [63:0] sum, output int lat);
    lat = -1;
    sum = '0;
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.signed_mode = sm;
    bus.mcand       = x;
    bus.mplr        = y;
    bus.out_ready   = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      #1;
      if (bus.out_valid) begin
        lat = c;
        sum = pp_sum();
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [63:0] sum;
    int          lat;
    int          nin, nout, seen;
    logic [63:0] exp_q [$];
    logic        held;
    logic [63:0] held_sum;
    logic        sm_r;
    logic [31:0] x_r, y_r;

    vecs[0]  = '{1'b1, 32'd3,          32'd5,          64'd15};
    vecs[1]  = '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'd1};
    vecs[2]  = '{1'b1, 32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};
    vecs[3]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
    vecs[4]  = '{1'b0, 32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000};
    vecs[5]  = '{1'b1, 32'd7,          32'hFFFF_FFFD,  64'hFFFF_FFFF_FFFF_FFEB};
    vecs[6]  = '{1'b0, 32'h1234_5678,  32'h10,         64'h0000_0001_2345_6780};
    vecs[7]  = '{1'b1, 32'h7FFF_FFFF,  32'h7FFF_FFFF,  64'h3FFF_FFFF_0000_0001};
    vecs[8]  = '{1'b1, 32'h8000_0000,  32'h7FFF_FFFF,  64'hC000_0000_8000_0000};
    vecs[9]  = '{1'b0, 32'h0,          32'hDEAD_BEEF,  64'h0};
    vecs[10] = '{1'b0, 32'hDEAD_BEEF,  32'h0,          64'h0};

    bus.in_valid    = 1'b0;
    bus.signed_mode = 1'b0;
    bus.mcand       = '0;
    bus.mplr        = '0;
    bus.out_ready   = 1'b0;

    // Reset state
    #2;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_pp_zero",   pp_or(0),           64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Individual partial products for 3*5 and (-1)*(-1)
    run_one(1'b1, 32'd3, 32'd5, sum, lat);
    check("lat_3x5",  64'(lat), 64'd2);
    check("pp1_3x5",  pps[0],   64'd3);
    check("pp2_3x5",  pps[1],   64'd12);
    check("pp3_18_3x5", pp_or(2), 64'd0);
    run_one(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, sum, lat);
    check("pp1_m1xm1",   pps[0],   64'd1);
    check("pp2_18_m1xm1", pp_or(1), 64'd0);

    // Directed product table
    for (int v = 0; v < 11; v++) begin
      run_one(vecs[v].sm, vecs[v].x, vecs[v].y, sum, lat);
      check($sformatf("tbl_lat_%0d", v), 64'(lat), 64'd2);
      check($sformatf("tbl_sum_%0d", v), sum, vecs[v].exp_sum);
    end

    // Backpressure: four offers with out_ready low, two accepted
    @(negedge clk);
    bus.out_ready   = 1'b0;
    bus.signed_mode = 1'b0;
    bus.mplr        = 32'd1;
    nin = 1;
    for (int c = 0; c < 4; c++) begin
      bus.in_valid = 1'b1;
      bus.mcand    = 32'(nin);
      #1;
      if (bus.in_ready) nin++;
      @(negedge clk);
    end
    #1;
    check("bp_accepts",   64'(nin - 1),       64'd2);
    check("bp_in_ready",  64'(bus.in_ready),  64'd0);
    check("bp_out_valid", 64'(bus.out_valid), 64'd1);
    check("bp_hold_set1", pp_sum(),           64'd1);
    nout = 1;
    for (int c = 0; c < 20; c++) begin
      bus.out_ready = 1'b1;
      bus.in_valid  = (nin <= 4);
      bus.mcand     = 32'(nin);
      #1;
      if (bus.out_valid) begin
        check("bp_order", pp_sum(), 64'(nout));
        nout++;
      end
      if (bus.in_valid && bus.in_ready) nin++;
      if (nout > 4 && nin > 4) break;
      @(negedge clk);
    end
    check("bp_count", 64'(nout), 64'd5);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("bp_no_dup", 64'(bus.out_valid), 64'd0);

    // Flush with both stages full and a same-cycle offer
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.mcand     = 32'h11;
    @(negedge clk);
    bus.mcand = 32'h22;
    @(negedge clk);
    #1;
    check("fl_pre_full", 64'(bus.in_ready), 64'd0);
    flush         = 1'b1;
    bus.mcand     = 32'h33;
    bus.out_ready = 1'b1;
    @(negedge clk);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("fl_out_valid", 64'(bus.out_valid), 64'd0);
    check("fl_in_ready",  64'(bus.in_ready),  64'd1);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check("fl_no_late_out", 64'(seen), 64'd0);

    // Reset in the middle of a held set
    @(negedge clk);
    bus.out_ready   = 1'b0;
    bus.in_valid    = 1'b1;
    bus.signed_mode = 1'b1;
    bus.mcand       = 32'd5;
    bus.mplr        = 32'd7;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("mr_pre_valid", 64'(bus.out_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mr_out_valid", 64'(bus.out_valid), 64'd0);
    check("mr_pp_zero",   pp_or(0),           64'd0);
    check("mr_in_ready",  64'(bus.in_ready),  64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_one(1'b1, 32'd9, 32'hFFFF_FFFC, sum, lat);
    check("mr_post_lat", 64'(lat), 64'd2);
    check("mr_post_sum", sum,      64'hFFFF_FFFF_FFFF_FFDC);

    // Randomized traffic against a product reference and an in-order queue
    held     = 1'b0;
    held_sum = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      sm_r = 1'($urandom_range(0, 1));
      x_r  = pick_operand();
      y_r  = pick_operand();
      bus.in_valid    = ($urandom_range(0, 3) != 0);
      bus.out_ready   = ($urandom_range(0, 2) != 0);
      bus.signed_mode = sm_r;
      bus.mcand       = x_r;
      bus.mplr        = y_r;
      #1;
      if (held) begin
        check("rnd_stall_valid", 64'(bus.out_valid), 64'd1);
        check("rnd_stall_sum",   pp_sum(),           held_sum);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("rnd_spurious", 64'd1, 64'd0);
        else check("rnd_sum", pp_sum(), exp_q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(ref_prod(sm_r, x_r, y_r));
      held     = bus.out_valid && !bus.out_ready;
      held_sum = pp_sum();
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) check("drain_spurious", 64'd1, 64'd0);
        else check("drain_sum", pp_sum(), exp_q.pop_front());
      end
      @(negedge clk);
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
